// File: rtl/audio_sd_dac.sv
// Multi-channel delta-sigma audio DAC with strobe-latched samples, a soft-mute gain ramp
// and a 1st/2nd-order modulator. Define AUDIO_SD_DAC_DITHER_EN to add per-channel LFSR dither.
module audio_sd_dac #(
  parameter int CHANNELS  = 2,
  parameter int WIDTH     = 16,
  parameter int ORDER     = 2,
  parameter int SIGNED_IN = 0,
  parameter int RAMP_DIV  = 1024
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic                      ce,
  input  logic                      sample_stb,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic                      mute,
  output logic                      muted,
  output logic [CHANNELS-1:0]       dac_o
);

  localparam int IW = WIDTH + 4;
  localparam int PW = WIDTH + 10;
  localparam int CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CW-1:0]        CNT_LAST = CW'(RAMP_DIV - 1);
  localparam logic [8:0]           GAIN_MAX = 9'd256;
  localparam logic signed [IW:0]   FB_POS   = (IW+1)'(2 ** (WIDTH - 1));
  localparam logic signed [IW:0]   FB_NEG   = -FB_POS;
  localparam logic signed [IW:0]   SAT_POS  = (IW+1)'(2 ** (WIDTH + 2));
  localparam logic signed [IW:0]   SAT_NEG  = -SAT_POS;

  if (ORDER != 1 && ORDER != 2) begin : g_bad_order
    $error("audio_sd_dac: ORDER must be 1 or 2");
  end

  logic signed [WIDTH-1:0] hold_q   [CHANNELS];
  logic signed [WIDTH-1:0] hold_d   [CHANNELS];
  logic signed [WIDTH-1:0] scaled_q [CHANNELS];
  logic signed [WIDTH-1:0] scaled_d [CHANNELS];
  logic signed [IW-1:0]    i1_q     [CHANNELS];
  logic signed [IW-1:0]    i1_d     [CHANNELS];
  logic signed [IW-1:0]    i2_q     [CHANNELS];
  logic signed [IW-1:0]    i2_d     [CHANNELS];
  logic [CHANNELS-1:0]     dac_q, dac_d;
  logic [8:0]              gain_q, gain_d;
  logic [CW-1:0]           ramp_cnt_q, ramp_cnt_d;
  logic                    muted_q, muted_d;
  logic                    ramp_wrap;

  logic [WIDTH-1:0]        din_k;
  logic signed [IW:0]      fb, sum1, sum2;
  logic signed [IW-1:0]    i1_nx, i2_nx;
  logic                    dac_nx;

  function automatic logic signed [IW-1:0] sat(input logic signed [IW:0] v);
    if (v > SAT_POS)      sat = IW'(SAT_POS);
    else if (v < SAT_NEG) sat = IW'(SAT_NEG);
    else                  sat = IW'(v);
  endfunction

`ifdef AUDIO_SD_DAC_DITHER_EN
  logic [15:0] lfsr_q [CHANNELS];
  logic [15:0] lfsr_d [CHANNELS];

  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      lfsr_d[k] = lfsr_q[k];
      if (ce) lfsr_d[k] = {1'b0, lfsr_q[k][15:1]} ^ (lfsr_q[k][0] ? 16'hB400 : 16'h0000);
    end
  end

  always_ff @(posedge clk_sys) begin
    for (int k = 0; k < CHANNELS; k++) begin
      if (reset) lfsr_q[k] <= 16'hACE1 ^ 16'(k);
      else       lfsr_q[k] <= lfsr_d[k];
    end
  end
`endif

  // NOTE: every variable gets a default at the top of the block so no path infers a latch.
  always_comb begin
    ramp_wrap  = (ramp_cnt_q == CNT_LAST);
    ramp_cnt_d = ramp_wrap ? '0 : ramp_cnt_q + CW'(1);
    gain_d     = gain_q;
    if (ramp_wrap) begin
      if (!mute && gain_q != GAIN_MAX) gain_d = gain_q + 9'd1;
      else if (mute && gain_q != 9'd0) gain_d = gain_q - 9'd1;
    end
    muted_d = (gain_q == 9'd0) && mute;
    dac_d   = dac_q;
    din_k   = '0;
    fb      = '0;
    sum1    = '0;
    sum2    = '0;
    i1_nx   = '0;
    i2_nx   = '0;
    dac_nx  = 1'b0;

    for (int k = 0; k < CHANNELS; k++) begin
      din_k     = din[k*WIDTH +: WIDTH];
      hold_d[k] = hold_q[k];
      if (sample_stb)
        hold_d[k] = (SIGNED_IN != 0) ? din_k : {~din_k[WIDTH-1], din_k[WIDTH-2:0]};

      // Gain is unity at 256, so the arithmetic shift by 8 is an exact pass-through there.
      scaled_d[k] = WIDTH'((PW'(hold_q[k]) * PW'($signed({1'b0, gain_q}))) >>> 8);

      fb    = dac_q[k] ? FB_POS : FB_NEG;
      sum1  = (IW+1)'(i1_q[k]) + (IW+1)'(scaled_q[k]) - fb;
`ifdef AUDIO_SD_DAC_DITHER_EN
      sum1  = sum1 + (IW+1)'(lfsr_q[k][0]);
`endif
      i2_nx = i2_q[k];
      if (ORDER == 1) begin
        i1_nx  = IW'(sum1);
        dac_nx = ~i1_nx[IW-1];
      end else begin
        i1_nx  = sat(sum1);
        sum2   = (IW+1)'(i2_q[k]) + (IW+1)'(i1_nx) - fb;
        i2_nx  = sat(sum2);
        dac_nx = ~i2_nx[IW-1];
      end

      i1_d[k] = ce ? i1_nx : i1_q[k];
      i2_d[k] = ce ? i2_nx : i2_q[k];
      if (ce) dac_d[k] = dac_nx;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      // NOTE: the per-channel arrays are a few flops each, not RAM, so they take the reset too.
      for (int k = 0; k < CHANNELS; k++) begin
        hold_q[k]   <= '0;
        scaled_q[k] <= '0;
        i1_q[k]     <= '0;
        i2_q[k]     <= '0;
      end
      dac_q      <= '0;
      gain_q     <= '0;
      ramp_cnt_q <= '0;
      muted_q    <= 1'b0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        hold_q[k]   <= hold_d[k];
        scaled_q[k] <= scaled_d[k];
        i1_q[k]     <= i1_d[k];
        i2_q[k]     <= i2_d[k];
      end
      dac_q      <= dac_d;
      gain_q     <= gain_d;
      ramp_cnt_q <= ramp_cnt_d;
      muted_q    <= muted_d;
    end
  end

  assign dac_o = dac_q;
  assign muted = muted_q;

endmodule

// File: tb/tb_audio_sd_dac.sv
// Directed bench for audio_sd_dac: a 4-channel 2nd-order unsigned instance and a
// 1-channel 1st-order signed instance, both WIDTH=8 and RAMP_DIV=4 to keep windows short.
module tb_audio_sd_dac;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, ce, sample_stb, mute;
  logic [4*W-1:0] din_a;
  logic [W-1:0] din_b;
  logic         muted_a, muted_b;
  logic [3:0]   dac_a;
  logic [0:0]   dac_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  audio_sd_dac #(.CHANNELS(4), .WIDTH(W), .ORDER(2), .SIGNED_IN(0), .RAMP_DIV(4)) u_a (
    .clk_sys(clk), .reset(reset), .ce(ce), .sample_stb(sample_stb),
    .din(din_a), .mute(mute), .muted(muted_a), .dac_o(dac_a)
  );

  audio_sd_dac #(.CHANNELS(1), .WIDTH(W), .ORDER(1), .SIGNED_IN(1), .RAMP_DIV(4)) u_b (
    .clk_sys(clk), .reset(reset), .ce(ce), .sample_stb(sample_stb),
    .din(din_b), .mute(mute), .muted(muted_b), .dac_o(dac_b)
  );

  // Expected ones over 1024 cycles = 4 * (x + 128), x the signed scaled sample.
  typedef struct {
    logic [31:0]      din_a;
    logic [7:0]       din_b;
    logic [3:0][10:0] exp_a;
    logic [10:0]      exp_b;
  } vec_t;

  vec_t vecs [3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_near(input string name, input int act, input int exp, input int tol);
    n_tests++;
    if (act > exp + tol || act < exp - tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  task automatic wait_gain(input int target, input int limit, input string name);
    int c = 0;
    while (int'(u_a.gain_q) != target && c < limit) begin
      tick();
      c++;
    end
    check(name, 32'(u_a.gain_q), 32'(target));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int         cnt_a [4];
    int         cnt_b, c, dac_chg, i1_chg;
    logic [3:0] prev_dac;
    logic signed [11:0] prev_i1;
    logic       muted_seen;

    vecs[0] = '{32'hFF00C080, 8'h40, {11'd1020, 11'd0,   11'd768, 11'd512}, 11'd768};
    vecs[1] = '{32'h90E02040, 8'hC0, {11'd576,  11'd896, 11'd128, 11'd256}, 11'd256};
    vecs[2] = '{32'h80808080, 8'h7F, {11'd512,  11'd512, 11'd512, 11'd512}, 11'd1020};

    // Reset dominates a strobe and mute held during reset.
    reset = 1'b1; ce = 1'b1; sample_stb = 1'b1; mute = 1'b1;
    din_a = '1; din_b = '1;
    repeat (3) tick();
    check("rst_dac_a",    32'(dac_a), 32'd0);
    check("rst_dac_b",    32'(dac_b), 32'd0);
    check("rst_muted",    32'({muted_a, muted_b}), 32'd0);
    check("rst_gain",     32'(u_a.gain_q), 32'd0);
    check("rst_hold",     32'($unsigned(u_a.hold_q[0])), 32'd0);
    check("rst_scaled_b", 32'($unsigned(u_b.scaled_q[0])), 32'd0);

    // Soft start: one gain step every 4 cycles, unity after exactly 1024 cycles.
    reset = 1'b0; sample_stb = 1'b0; mute = 1'b0;
    din_a = 32'h80808080; din_b = 8'h00;
    muted_seen = 1'b0;
    for (int n = 1; n <= 1024; n++) begin
      tick();
      muted_seen = muted_seen | muted_a | muted_b;
      if (n == 3)    check("ramp_before_first", 32'(u_a.gain_q), 32'd0);
      if (n == 4)    check("ramp_first_step",   32'(u_a.gain_q), 32'd1);
      if (n == 1023) check("ramp_at_1023",      32'(u_a.gain_q), 32'd255);
      if (n == 1024) check("ramp_at_1024",      32'(u_a.gain_q), 32'd256);
    end
    repeat (8) tick();
    check("ramp_saturates", 32'(u_a.gain_q), 32'd256);
    check("ramp_muted_low", 32'(muted_seen), 32'd0);

    // Density vectors at unity gain.
    for (int v = 0; v < 3; v++) begin
      din_a = vecs[v].din_a;
      din_b = vecs[v].din_b;
      sample_stb = 1'b1;
      tick();
      sample_stb = 1'b0;
      repeat (128) tick();
      for (int k = 0; k < 4; k++) cnt_a[k] = 0;
      cnt_b = 0;
      repeat (1024) begin
        tick();
        for (int k = 0; k < 4; k++) cnt_a[k] += int'(dac_a[k]);
        cnt_b += int'(dac_b[0]);
      end
      for (int k = 0; k < 4; k++)
        check_near($sformatf("density_v%0d_a%0d", v, k), cnt_a[k], int'(vecs[v].exp_a[k]), 4);
      check_near($sformatf("density_v%0d_b", v), cnt_b, int'(vecs[v].exp_b), 4);
    end

    // Latency: hold one cycle after the strobe edge, scaled one cycle later.
    din_a = 32'h80808012; din_b = 8'h40;
    sample_stb = 1'b1;
    tick();
    sample_stb = 1'b0;
    check("lat_hold_a",     32'($unsigned(u_a.hold_q[0])),   32'h92);
    check("lat_hold_b",     32'($unsigned(u_b.hold_q[0])),   32'h40);
    check("lat_scaled_old", 32'($unsigned(u_a.scaled_q[0])), 32'h00);
    tick();
    check("lat_scaled_new", 32'($unsigned(u_a.scaled_q[0])), 32'h92);

    // Mute ramp down; half gain scaling of signed and converted samples.
    mute = 1'b1;
    wait_gain(128, 1200, "gain_reach_128");
    tick();
    check("scaled_b_g128", 32'($unsigned(u_b.scaled_q[0])), 32'h20);
    check("scaled_a_g128", 32'($unsigned(u_a.scaled_q[0])), 32'hC9);
    wait_gain(100, 200, "gain_reach_100");
    c = 0;
    while (u_a.gain_q != 9'd0 && c < 1000) begin
      tick();
      c++;
    end
    check("mute_100_to_0_cycles", 32'(c), 32'd400);
    check("muted_lags_gain", 32'(muted_a), 32'd0);
    tick();
    check("muted_high", 32'({muted_a, muted_b}), 32'd3);

    // Unmute, then reverse direction mid-ramp.
    mute = 1'b0;
    tick();
    check("muted_clears", 32'({muted_a, muted_b}), 32'd0);
    wait_gain(60, 400, "gain_up_60");
    mute = 1'b1;
    wait_gain(50, 100, "gain_down_50");
    tick();
    tick();
    mute = 1'b0;
    c = 0;
    while (u_a.gain_q == 9'd50 && c < 10) begin
      tick();
      c++;
    end
    check("reverse_step", 32'(u_a.gain_q), 32'd51);

    // ce low freezes modulator state while hold keeps latching.
    din_a = 32'h80808080;
    sample_stb = 1'b1;
    tick();
    sample_stb = 1'b0;
    repeat (20) tick();
    ce = 1'b0;
    prev_dac = dac_a;
    prev_i1  = u_a.i1_q[0];
    dac_chg  = 0;
    i1_chg   = 0;
    for (int n = 0; n < 10; n++) begin
      if (n == 3) begin
        din_a = 32'h80808055;
        sample_stb = 1'b1;
      end
      tick();
      if (n == 3) begin
        sample_stb = 1'b0;
        check("ce0_hold_updates", 32'($unsigned(u_a.hold_q[0])), 32'hD5);
      end
      if (dac_a !== prev_dac) dac_chg++;
      if (u_a.i1_q[0] !== prev_i1) i1_chg++;
      prev_dac = dac_a;
      prev_i1  = u_a.i1_q[0];
    end
    check("ce0_dac_frozen", 32'(dac_chg), 32'd0);
    check("ce0_i1_frozen",  32'(i1_chg),  32'd0);
    ce = 1'b1;
    dac_chg = 0;
    repeat (16) begin
      tick();
      if (dac_a !== prev_dac) dac_chg++;
      prev_dac = dac_a;
    end
    check("ce1_resumes", 32'(dac_chg > 0), 32'd1);

    // Reset again with strobe and mute active.
    reset = 1'b1; sample_stb = 1'b1; mute = 1'b1;
    tick();
    check("rst2_dac",  32'(dac_a), 32'd0);
    check("rst2_gain", 32'(u_a.gain_q), 32'd0);
    check("rst2_hold", 32'($unsigned(u_a.hold_q[0])), 32'd0);
    check("rst2_i1",   32'($unsigned(u_a.i1_q[0])), 32'd0);
    reset = 1'b0; sample_stb = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
